// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/flush handshake between the ID stage and the register scoreboard.
// The master modport is the pipeline side and the slave modport is the scoreboard.
interface reg_scoreboard_if #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
    logic                i_issue_valid;
    logic [4:0]          i_issue_rs1;
    logic [4:0]          i_issue_rs2;
    logic                i_issue_uses_rs1;
    logic                i_issue_uses_rs2;
    logic [4:0]          i_issue_rd;
    logic                i_issue_rd_write;
    logic                i_issue_long;
    logic                i_wb_valid;
    logic [4:0]          i_wb_rd;
    logic                i_flush;
    logic                o_stall;
    logic [NUM_REGS-1:0] o_pending;
    logic [CNT_W-1:0]    o_outstanding;

    modport master (
        output i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_uses_rs1, i_issue_uses_rs2,
               i_issue_rd, i_issue_rd_write, i_issue_long, i_wb_valid, i_wb_rd, i_flush,
        input  o_stall, o_pending, o_outstanding
    );

    modport slave (
        input  i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_uses_rs1, i_issue_uses_rs2,
               i_issue_rd, i_issue_rd_write, i_issue_long, i_wb_valid, i_wb_rd, i_flush,
        output o_stall, o_pending, o_outstanding
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-register tracker for long-latency ops; bits visible one cycle after issue.
// o_stall is combinational and holds ID on RAW/WAW against pending regs or a full in-flight cap.
module reg_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic             i_clk,
    input logic             i_rst_n,
    reg_scoreboard_if.slave sb
);
    localparam int CW1 = CNT_W + 1;
    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_outstanding;
    logic                r_last_vld;
    logic [4:0]          r_last_rd;

    logic [NUM_REGS-1:0] w_wb_mask;
    logic [NUM_REGS-1:0] w_eff;
    logic [NUM_REGS-1:0] w_wb_clr_mask;
    logic [NUM_REGS-1:0] w_fl_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic                w_wb_clr;
    logic                w_fl_clr;
    logic                w_same;
    logic                w_cap_full;
    logic                w_hazard;
    logic                w_stall;
    logic                w_accept;
    logic                w_set;
    logic [1:0]          w_nclr;
    logic [CNT_W:0]      w_cnt_nxt;

    // A same-cycle writeback hides the pending bit: forwarding delivers the value.
    assign w_wb_mask     = (sb.i_wb_valid && sb.i_wb_rd != 5'd0) ? (ONE << sb.i_wb_rd) : '0;
    assign w_eff         = r_pending & ~w_wb_mask;
    assign w_wb_clr_mask = r_pending & w_wb_mask;
    assign w_wb_clr      = |w_wb_clr_mask;

    assign w_cap_full = (r_outstanding == CNT_W'(MAX_OUTSTANDING)) && !w_wb_clr;
    assign w_hazard   = (sb.i_issue_uses_rs1 && w_eff[sb.i_issue_rs1])
                     || (sb.i_issue_uses_rs2 && w_eff[sb.i_issue_rs2])
                     || (sb.i_issue_long && sb.i_issue_rd_write && w_eff[sb.i_issue_rd])
                     || (sb.i_issue_long && w_cap_full);
    assign w_stall    = i_rst_n && sb.i_issue_valid && !sb.i_flush && w_hazard;
    assign w_accept   = sb.i_issue_valid && !w_stall && !sb.i_flush;
    assign w_set      = w_accept && sb.i_issue_long && sb.i_issue_rd_write && (sb.i_issue_rd != 5'd0);
    assign w_set_mask = w_set ? (ONE << sb.i_issue_rd) : '0;

    // The op issued last cycle is the one sitting in EX, so a flush retracts its mark.
    assign w_fl_clr  = sb.i_flush && r_last_vld && r_pending[r_last_rd];
    assign w_fl_mask = w_fl_clr ? (ONE << r_last_rd) : '0;
    assign w_same    = w_wb_clr && w_fl_clr && (sb.i_wb_rd == r_last_rd);
    assign w_nclr    = 2'(w_wb_clr) + 2'(w_fl_clr) - 2'(w_same);
    assign w_cnt_nxt = {1'b0, r_outstanding} + CW1'(w_set) - CW1'(w_nclr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_last_vld    <= 1'b0;
            r_last_rd     <= 5'd0;
        end else begin
            r_pending     <= (r_pending & ~(w_wb_clr_mask | w_fl_mask)) | w_set_mask;
            r_outstanding <= w_cnt_nxt[CNT_W-1:0];
            r_last_vld    <= w_set;
            r_last_rd     <= w_set ? sb.i_issue_rd : 5'd0;
        end
    end

    assign sb.o_stall       = w_stall;
    assign sb.o_pending     = r_pending;
    assign sb.o_outstanding = r_outstanding;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table of per-cycle stimulus with hand-computed stall/pending/count, plus an async reset sequence.
module tb_reg_scoreboard;
    logic clk;
    logic rst_n;

    reg_scoreboard_if sbif ();

    reg_scoreboard dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sb      (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rdw;
        logic        lng;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        e_stall;
        logic [31:0] e_pend;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rdw, input logic lng,
                                input logic wbv, input logic [4:0] wbrd, input logic fl,
                                input logic es, input logic [31:0] ep, input logic [2:0] ec);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.rdw = rdw; t.lng = lng; t.wbv = wbv; t.wbrd = wbrd; t.fl = fl;
        t.e_stall = es; t.e_pend = ep; t.e_cnt = ec;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        sbif.i_issue_valid    = t.v;
        sbif.i_issue_rs1      = t.rs1;
        sbif.i_issue_uses_rs1 = t.u1;
        sbif.i_issue_rs2      = t.rs2;
        sbif.i_issue_uses_rs2 = t.u2;
        sbif.i_issue_rd       = t.rd;
        sbif.i_issue_rd_write = t.rdw;
        sbif.i_issue_long     = t.lng;
        sbif.i_wb_valid       = t.wbv;
        sbif.i_wb_rd          = t.wbrd;
        sbif.i_flush          = t.fl;
    endtask

    task automatic idle();
        vec_t t;
        t = '{default: '0};
        drive(t);
    endtask

    task automatic issue_long(input logic [4:0] rd);
        vec_t t;
        t = '{default: '0};
        t.v = 1'b1; t.rd = rd; t.rdw = 1'b1; t.lng = 1'b1;
        drive(t);
    endtask

    initial begin
        vec_t t;
        // load-use
        add(1, 0,0, 0,0, 5,1,1, 0,0, 0, 0, 32'h20, 1);
        add(1, 5,1, 0,0, 0,0,0, 0,0, 0, 1, 32'h20, 1);
        add(1, 5,0, 5,1, 0,0,0, 0,0, 0, 1, 32'h20, 1);
        add(1, 5,1, 0,0, 0,0,0, 1,5, 0, 0, 32'h0,  0);
        // x0 and short ops
        add(1, 0,0, 0,0, 0,1,1, 0,0, 0, 0, 32'h0,  0);
        add(1, 0,0, 0,0, 7,1,0, 0,0, 0, 0, 32'h0,  0);
        add(1, 0,1, 7,1, 0,0,0, 0,0, 0, 0, 32'h0,  0);
        // fill to the cap, then cap stall, same-cycle release, WAW
        add(1, 0,0, 0,0, 1,1,1, 0,0, 0, 0, 32'h02, 1);
        add(1, 0,0, 0,0, 2,1,1, 0,0, 0, 0, 32'h06, 2);
        add(1, 0,0, 0,0, 3,1,1, 0,0, 0, 0, 32'h0E, 3);
        add(1, 0,0, 0,0, 4,1,1, 0,0, 0, 0, 32'h1E, 4);
        add(1, 0,0, 0,0, 6,1,1, 0,0, 0, 1, 32'h1E, 4);
        add(1, 0,0, 0,0, 6,1,1, 1,2, 0, 0, 32'h5A, 4);
        add(1, 0,0, 0,0, 3,1,1, 1,1, 0, 1, 32'h58, 3);
        add(0, 0,0, 0,0, 0,0,0, 1,3, 0, 0, 32'h50, 2);
        add(0, 0,0, 0,0, 0,0,0, 1,4, 0, 0, 32'h40, 1);
        add(0, 0,0, 0,0, 0,0,0, 1,6, 0, 0, 32'h0,  0);
        add(0, 0,0, 0,0, 0,0,0, 1,10,0, 0, 32'h0,  0);
        // flush cancel, and a flush with no long op in EX
        add(1, 0,0, 0,0, 9,1,1, 0,0, 0, 0, 32'h200, 1);
        add(1, 0,0, 0,0, 11,1,1,0,0, 1, 0, 32'h0,   0);
        add(0, 0,0, 0,0, 0,0,0, 1,9, 0, 0, 32'h0,   0);
        add(1, 0,0, 0,0, 12,1,1,0,0, 0, 0, 32'h1000, 1);
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0, 32'h1000, 1);
        add(1, 0,0, 0,0, 11,1,1,0,0, 1, 0, 32'h1000, 1);
        add(0, 0,0, 0,0, 0,0,0, 1,12,0, 0, 32'h0,    0);
        // simultaneous set/clear, flush+wb same rd, flush+wb distinct rds
        add(1, 0,0, 0,0, 8,1,1, 0,0, 0, 0, 32'h100, 1);
        add(1, 0,0, 0,0, 8,1,1, 1,8, 0, 0, 32'h100, 1);
        add(0, 0,0, 0,0, 0,0,0, 1,8, 1, 0, 32'h0,   0);
        add(1, 0,0, 0,0, 13,1,1,0,0, 0, 0, 32'h2000, 1);
        add(1, 0,0, 0,0, 14,1,1,0,0, 0, 0, 32'h6000, 2);
        add(0, 0,0, 0,0, 0,0,0, 1,13,1, 0, 32'h0,    0);

        // reset state, with an issue request presented during reset
        rst_n = 1'b1;
        idle();
        sbif.i_issue_valid = 1'b1; sbif.i_issue_long = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_stall", 32'(sbif.o_stall), 32'h0);
        chk("reset_pending", sbif.o_pending, 32'h0);
        chk("reset_count", 32'(sbif.o_outstanding), 32'h0);
        @(posedge clk); #3;
        idle();
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            t = vq[i];
            drive(t);
            #3;
            chk($sformatf("v%0d_stall", i), 32'(sbif.o_stall), 32'(t.e_stall));
            @(posedge clk); #1;
            chk($sformatf("v%0d_pending", i), sbif.o_pending, t.e_pend);
            chk($sformatf("v%0d_count", i), 32'(sbif.o_outstanding), 32'(t.e_cnt));
        end

        // asynchronous reset mid-cycle with three long ops outstanding
        issue_long(5'd1); @(posedge clk); #1;
        issue_long(5'd2); @(posedge clk); #1;
        issue_long(5'd3); @(posedge clk); #1;
        idle();
        chk("pre_rst_count", 32'(sbif.o_outstanding), 32'd3);
        chk("pre_rst_pending", sbif.o_pending, 32'h0E);
        sbif.i_issue_valid = 1'b1; sbif.i_issue_rs1 = 5'd1; sbif.i_issue_uses_rs1 = 1'b1;
        #1;
        chk("pre_rst_stall", 32'(sbif.o_stall), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_pending", sbif.o_pending, 32'h0);
        chk("midrst_count", 32'(sbif.o_outstanding), 32'h0);
        chk("midrst_stall", 32'(sbif.o_stall), 32'h0);
        idle();
        sbif.i_wb_valid = 1'b1; sbif.i_wb_rd = 5'd2;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_wb_pending", sbif.o_pending, 32'h0);
        chk("post_rst_wb_count", 32'(sbif.o_outstanding), 32'h0);
        issue_long(5'd4); @(posedge clk); #1;
        idle();
        chk("post_rst_set_pending", sbif.o_pending, 32'h10);
        chk("post_rst_set_count", 32'(sbif.o_outstanding), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
